// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam logic        UART_STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line input; resets to 1 (idle line).
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver, 8 data bits LSB first, one stop bit, level ready/ack handshake.
// Optional parity bit, parity_err port and PARITY_ODD parameter via UART_RX_PARITY_EN.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   data_ack,
  output logic [UART_DATA_W-1:0] received_data,
  output logic                   data_ready,
  output logic                   frame_err,
  output logic                   overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   rx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_W);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_W - 1);

  logic                   w_rx_s;
  logic                   r_rx_h;
  uart_state_e            r_state, w_state_n;
  logic [CW-1:0]          r_cnt, w_cnt_n;
  logic [IW-1:0]          r_idx, w_idx_n;
  logic [UART_DATA_W-1:0] r_shift, w_shift_n;
  logic [UART_DATA_W-1:0] r_data, w_data_n;
  logic                   r_ready, w_ready_n;
  logic                   r_ferr, w_ferr_n;
  logic                   r_oerr, w_oerr_n;
  logic                   w_cnt_last;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_stop_ok;
  logic                   w_par_ok;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par_n;
  logic                   r_perr, w_perr_n;
`endif

  uart_sync2 u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_h  <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_rx_h  <= w_rx_s;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_ready <= w_ready_n;
      r_ferr  <= w_ferr_n;
      r_oerr  <= w_oerr_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
      r_perr  <= w_perr_n;
`endif
    end
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = w_cnt_last ? '0 : r_cnt + CW'(1);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt_inc;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_ready_n = r_ready & ~data_ack;
    w_ferr_n  = 1'b0;
    w_oerr_n  = 1'b0;
    w_stop_ok = 1'b0;
    w_par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
    w_perr_n  = 1'b0;
`endif
    case (r_state)
      // Only entered with the line high, so a low history bit here is the falling edge.
      IDLE: begin
        w_cnt_n = '0;
        if (!r_rx_h) w_state_n = START;
      end
      START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = r_rx_h ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_cnt_last) begin
          w_shift_n = {r_rx_h, r_shift[UART_DATA_W-1:1]};
          w_idx_n   = r_idx + IW'(1);
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_n = PARITY;
`else
            w_state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_last) begin
          w_par_n   = r_rx_h;
          w_state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (w_cnt_last) begin
          w_stop_ok = (r_rx_h == UART_STOP_LEVEL);
          w_ferr_n  = ~w_stop_ok;
          w_state_n = w_stop_ok ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
          w_par_ok  = (((^r_shift) ^ r_par) == PARITY_ODD);
          w_perr_n  = ~w_par_ok;
`endif
          // A good byte wins over a same-cycle ack, and only counts as overrun if unacked.
          if (w_stop_ok && w_par_ok) begin
            w_data_n  = r_shift;
            w_ready_n = 1'b1;
            w_oerr_n  = r_ready & ~data_ack;
          end
        end
      end
      BREAK: begin
        w_cnt_n = '0;
        if (r_rx_h) w_state_n = IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
    endcase
  end

  assign received_data = r_data;
  assign data_ready    = r_ready;
  assign frame_err     = r_ferr;
  assign overrun_err   = r_oerr;
  assign rx_busy       = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err    = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit; parity scenarios under UART_RX_PARITY_EN.
module tb_uart_rx_frame;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Start-edge to stop-sample distance: 3 + C/2 + 9*C, plus C with parity.
  localparam int STOP_OFF = 3 + C / 2 + (NBITS - 1) * C;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       data_ack;
  logic [7:0] received_data;
  logic       data_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e_cyc    = 0;
  int rdy_rise = -1;
  int busy_rise = -1;
  int ferr_cnt = 0;
  int ferr_cyc = -1;
  int oerr_cnt = 0;
  int perr_cnt = 0;
  int perr_cyc = -1;
  logic prev_rdy  = 1'b0;
  logic prev_busy = 1'b0;

  uart_rx_frame #(
    .CLKS_PER_BIT (C)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD   (1'b0)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_ack      (data_ack),
    .received_data (received_data),
    .data_ready    (data_ready),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err    (parity_err),
`endif
    .rx_busy       (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_ready && !prev_rdy) rdy_rise = cyc;
    if (rx_busy && !prev_busy) busy_rise = cyc;
    if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    if (overrun_err) oerr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin perr_cnt++; perr_cyc = cyc; end
`endif
    prev_rdy  = data_ready;
    prev_busy = rx_busy;
  end

  // Frame bits, LSB driven first: start, data, [even parity], stop, idle.
  function automatic logic [11:0] mk(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {1'b1, stop, ^d, d, 1'b0};
`else
    return {2'b11, stop, d, 1'b0};
`endif
  endfunction

  // Called just after a negedge; the following posedge is E (e_cyc).
  task automatic send_frame(input logic [11:0] f, input int ack_at, input int ncyc);
    e_cyc = cyc + 1;
    for (int i = 0; i < ncyc; i++) begin
      rx       = f[i / C];
      data_ack = (i == ack_at);
      @(negedge clk);
    end
    data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; data_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (received_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", received_data); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", frame_err, overrun_err); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
`ifdef UART_RX_PARITY_EN
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
`endif
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic;
    send_frame(mk(8'hDA, 1'b1), -1, NBITS * C);
    n_checks++; if (received_data !== 8'hDA) begin n_fail++; $display("FAIL basic_data: got %h expected da", received_data); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", data_ready); end
    n_checks++; if (rdy_rise !== e_cyc + STOP_OFF) begin n_fail++; $display("FAIL basic_ready_time: got %0d expected %0d", rdy_rise - e_cyc, STOP_OFF); end
    n_checks++; if (busy_rise !== e_cyc + 3) begin n_fail++; $display("FAIL basic_busy_time: got %0d expected 3", busy_rise - e_cyc); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", rx_busy); end
    n_checks++; if (ferr_cnt !== 0 || oerr_cnt !== 0 || perr_cnt !== 0) begin n_fail++; $display("FAIL basic_no_err: got %0d/%0d/%0d expected 0/0/0", ferr_cnt, oerr_cnt, perr_cnt); end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got %b expected 0", data_ready); end
    // A second ack with nothing pending must not disturb anything.
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    n_checks++; if (data_ready !== 1'b0 || received_data !== 8'hDA) begin n_fail++; $display("FAIL basic_idle_ack: got %b/%h expected 0/da", data_ready, received_data); end
    idle(4);
  endtask

  task automatic test_false_start;
    int f0;
    f0 = ferr_cnt;
    e_cyc = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(24);
    n_checks++; if (busy_rise !== e_cyc + 3) begin n_fail++; $display("FAIL glitch_start: got %0d expected 3", busy_rise - e_cyc); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
    n_checks++; if (data_ready !== 1'b0 || ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_quiet: got ready %b ferr %0d expected 0 %0d", data_ready, ferr_cnt, f0); end
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = ferr_cnt;
    send_frame(mk(8'h3C, 1'b0), -1, NBITS * C);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    n_checks++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    n_checks++; if (ferr_cyc !== e_cyc + STOP_OFF) begin n_fail++; $display("FAIL ferr_time: got %0d expected %0d", ferr_cyc - e_cyc, STOP_OFF); end
    n_checks++; if (received_data !== 8'hDA || data_ready !== 1'b0) begin n_fail++; $display("FAIL ferr_keep: got %h/%b expected da/0", received_data, data_ready); end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break: got %b expected 1", rx_busy); end
    idle(6);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: got %b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int o0;
    o0 = oerr_cnt;
    send_frame(mk(8'h55, 1'b1), -1, NBITS * C);
    n_checks++; if (oerr_cnt !== o0 || received_data !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got oerr %0d data %h expected %0d 55", oerr_cnt, received_data, o0); end
    send_frame(mk(8'hA3, 1'b1), -1, NBITS * C);
    idle(4);
    n_checks++; if (oerr_cnt !== o0 + 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected %0d", oerr_cnt, o0 + 1); end
    n_checks++; if (received_data !== 8'hA3 || data_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_data: got %h/%b expected a3/1", received_data, data_ready); end
  endtask

  task automatic test_ack_collision;
    int o0;
    o0 = oerr_cnt;
    send_frame(mk(8'h0F, 1'b1), STOP_OFF, NBITS * C);
    idle(4);
    n_checks++; if (received_data !== 8'h0F || data_ready !== 1'b1) begin n_fail++; $display("FAIL collide_data: got %h/%b expected 0f/1", received_data, data_ready); end
    n_checks++; if (oerr_cnt !== o0) begin n_fail++; $display("FAIL collide_no_overrun: got %0d expected %0d", oerr_cnt, o0); end
  endtask

  task automatic test_reset_midframe;
    send_frame(mk(8'h81, 1'b1), -1, 5 * C + C / 2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (received_data !== 8'h00 || data_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got %h/%b expected 00/0", received_data, data_ready); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
    idle(3);
    rst_n = 1'b1;
    idle(3);
    send_frame(mk(8'h81, 1'b1), -1, NBITS * C);
    idle(4);
    n_checks++; if (received_data !== 8'h81 || data_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_after: got %h/%b expected 81/1", received_data, data_ready); end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    idle(2);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity_err;
    int p0;
    int f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame({1'b1, 1'b1, 1'b0, 8'hDA, 1'b0}, -1, NBITS * C);
    idle(4);
    n_checks++; if (perr_cnt !== p0 + 1) begin n_fail++; $display("FAIL perr_pulse: got %0d cycles expected 1", perr_cnt - p0); end
    n_checks++; if (perr_cyc !== e_cyc + STOP_OFF) begin n_fail++; $display("FAIL perr_time: got %0d expected %0d", perr_cyc - e_cyc, STOP_OFF); end
    n_checks++; if (data_ready !== 1'b0 || received_data !== 8'h81) begin n_fail++; $display("FAIL perr_discard: got %b/%h expected 0/81", data_ready, received_data); end
    n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL perr_no_ferr: got %0d expected %0d", ferr_cnt, f0); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_frame_err;
    test_back_to_back;
    test_ack_collision;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity_err;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Standalone UART receiver that recovers 8-bit bytes from an asynchronous serial line. The format is 8N1, LSB first, with optional parity. The block synchronizes `rx`, validates the start bit at mid-bit, and samples each bit at its centre. It reports each byte through a level `data_ready` / `data_ack` handshake, with framing and overrun error pulses. It is the receive end that pairs with the team's UART transmit path and sits between the pad-level `rx` line and the byte-consuming logic.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per serial bit (100 MHz / 115200). Must be ≥ 4.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: asynchronous serial line; idle high.
- `data_ack` input 1: consumer acknowledge; clears `data_ready`.
- `received_data` output 8: last good byte; held until the next good frame.
- `data_ready` output 1: level; a byte is waiting.
- `frame_err` output 1: one-cycle pulse; stop bit sampled 0.
- `overrun_err` output 1: one-cycle pulse; a good byte completed while `data_ready` was already 1.
- `parity_err` output 1: one-cycle pulse. Present only with `UART_RX_PARITY_EN`.
- `rx_busy` output 1: high in any state other than IDLE.

## Operation
- Reset values: `received_data`=8'h00; `data_ready`, `frame_err`, `overrun_err`, `parity_err`, `rx_busy` = 0. State = IDLE. Synchronizer flops = 1 (line idle).
- `rx` passes through a 2-flop synchronizer, then a 1-flop history register used for falling-edge detect.
- Bit counter: width `$clog2(CLKS_PER_BIT)`. It counts from 0 and wraps at `CLKS_PER_BIT-1`.
- State machine:
  - IDLE: a synchronized falling edge moves to START and clears the counter.
  - START: at count `CLKS_PER_BIT/2 - 1` (floor), sample the line.
    - Sample is 0: move to DATA and clear the counter.
    - Sample is 1: false start; return to IDLE. No flags.
  - DATA: at each count `CLKS_PER_BIT-1`, shift the sample into bit[index], LSB first. After bit 7, move to PARITY if enabled, otherwise to STOP.
  - PARITY: sample at `CLKS_PER_BIT-1`, then move to STOP.
  - STOP: sample at `CLKS_PER_BIT-1`.
    - Sample is 1 (good frame): load `received_data` and set `data_ready` on that edge, then go to IDLE.
    - Sample is 0: pulse `frame_err`; `received_data` and `data_ready` are unchanged. Go to BREAK.
  - BREAK: wait for the synchronized line to read 1, then go to IDLE. This prevents a held-low line from being treated as a stream of start bits.
- Handshake:
  - `data_ack` while `data_ready`=1 clears `data_ready` on the next edge.
  - `data_ack` while `data_ready`=0 is ignored.
- Overrun: a good frame completes while `data_ready`=1 and `data_ack`=0.
  - `received_data` is overwritten.
  - `data_ready` stays 1.
  - `overrun_err` pulses.
- Simultaneous good-frame completion and `data_ack`: the new byte loads, `data_ready` stays 1, and there is no overrun.
- A new start bit is accepted in the cycle after returning to IDLE. Back-to-back frames need no gap beyond one stop bit.
- `rst_n` deasserted mid-frame: all state returns to its reset value immediately and the partial byte is discarded.

## Timing
- Let C = `CLKS_PER_BIT` and E = the edge at which raw `rx` is first registered low.
  - IDLE→START occurs at E+3.
  - Start sample occurs at E+3+floor(C/2).
  - Data bit k is sampled at E+3+floor(C/2)+(k+1)·C.
  - The stop sample, and `data_ready` rising, occur at E+3+floor(C/2)+9·C. Add C with parity enabled.
- Error pulses are exactly one cycle, coincident with the stop or parity sample edge.
- `rx_busy` rises at E+3 and falls on the edge where the state enters IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state, the `parity_err` port, and parameter `PARITY_ODD` (default 0 = even).
  - A parity mismatch pulses `parity_err` at the stop-sample edge together with the stop decision. The byte is discarded (`received_data` and `data_ready` are unchanged) even if the stop bit is good.
- Macro undefined: no PARITY state, no `parity_err` port, and the frame is 10 bits.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `BREAK`);
  - `UART_DATA_W`=8 and `UART_STOP_LEVEL`=1.
- Sub-module `uart_sync2`: a 2-flop synchronizer with an async active-low reset value of 1. It is reusable by other line inputs.

## Test plan
All scenarios use C=16.
- Drive 0xDA (8N1) → `received_data`=8'hDA, with `data_ready` rising exactly 3+8+144=155 cycles after the start edge. `data_ack` one cycle later → `data_ready`=0.
- Low glitch of 4 cycles on `rx` → START aborts at the mid-bit sample. No `data_ready`, no error pulse, back in IDLE.
- Send 0x3C with stop bit = 0 → `frame_err` single pulse, `received_data` keeps its previous value, and the block waits in BREAK until `rx`=1.
- Send 0x55 then 0xA3 back-to-back with no `data_ack` → `overrun_err` pulse on the second frame, `received_data`=8'hA3, `data_ready`=1.
- Assert `rst_n`=0 during data bit 4, release, then send 0x81 → all outputs 0 during reset, then `received_data`=8'h81.
- With `UART_RX_PARITY_EN` and even parity:
  - 0xDA with parity bit 1 → good byte.
  - 0xDA with parity bit 0 → `parity_err` pulse and `data_ready` stays 0.
